// File: rtl/lag_fifo_v.sv
// First-word-fall-through flit FIFO with occupancy flags.
// Define LAG_ROUTE_EN to rewrite the output-port field of head flits with an XY route.
module lag_fifo_v #(
    parameter int size         = 4,
    parameter int dw           = 64,
    parameter int head_bit     = 63,
    parameter int router_radix = 5,
    parameter int x_addr_bits  = 2,
    parameter int y_addr_bits  = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [dw-1:0] data_in,
    output logic [dw-1:0] data_out,
    output logic [3:0]    flags
);

    localparam int ptr_w = (size > 1) ? $clog2(size) : 1;
    localparam int cnt_w = $clog2(size + 1);
    localparam int x_lo  = router_radix;
    localparam int y_lo  = router_radix + x_addr_bits + 1;

    localparam logic [ptr_w-1:0] last_ptr  = ptr_w'(size - 1);
    localparam logic [ptr_w-1:0] zero_ptr  = {ptr_w{1'b0}};
    localparam logic [cnt_w-1:0] zero_cnt  = {cnt_w{1'b0}};
    localparam logic [cnt_w-1:0] one_cnt   = cnt_w'(1);
    localparam logic [cnt_w-1:0] full_cnt  = cnt_w'(size);
    localparam logic [cnt_w-1:0] nfull_cnt = cnt_w'(size - 1);

    logic [dw-1:0]    mem_r [size];
    logic [ptr_w-1:0] rd_ptr_r;
    logic [ptr_w-1:0] wr_ptr_r;
    logic [cnt_w-1:0] count_r;
    logic             do_push_s;
    logic             do_pop_s;
    logic [dw-1:0]    head_s;

    function automatic logic [ptr_w-1:0] next_ptr(input logic [ptr_w-1:0] p);
        if (p == last_ptr) begin
            return zero_ptr;
        end else begin
            return p + ptr_w'(1'b1);
        end
    endfunction

    // X has priority over Y; displacement fields are two's complement.
    function automatic logic [dw-1:0] route_flit(input logic [dw-1:0] f);
        logic [x_addr_bits:0] x_v;
        logic [y_addr_bits:0] y_v;
        logic [4:0]           port_v;
        logic [dw-1:0]        r_v;
        x_v    = f[x_lo +: x_addr_bits + 1];
        y_v    = f[y_lo +: y_addr_bits + 1];
        port_v = 5'b10000;
        r_v    = f;
        if (!f[head_bit]) begin
            r_v = f;
        end else if (x_v[x_addr_bits]) begin
            port_v = 5'b01000;
        end else if (x_v != {(x_addr_bits + 1){1'b0}}) begin
            port_v = 5'b00010;
        end else if (y_v[y_addr_bits]) begin
            port_v = 5'b00100;
        end else if (y_v != {(y_addr_bits + 1){1'b0}}) begin
            port_v = 5'b00001;
        end else begin
            port_v = 5'b10000;
        end
        if (f[head_bit]) begin
            r_v[router_radix-1:0] = router_radix'(port_v);
        end else begin
            r_v = f;
        end
        return r_v;
    endfunction

    // Accept decisions: a pop on a full FIFO frees the slot a same-cycle push uses.
    always_comb begin
        do_pop_s  = 1'b0;
        do_push_s = 1'b0;
        if (pop && (count_r != zero_cnt)) begin
            do_pop_s = 1'b1;
        end else begin
            do_pop_s = 1'b0;
        end
        if (push && ((count_r != full_cnt) || do_pop_s)) begin
            do_push_s = 1'b1;
        end else begin
            do_push_s = 1'b0;
        end
    end

    // Pointer and occupancy state with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            rd_ptr_r <= zero_ptr;
            wr_ptr_r <= zero_ptr;
            count_r  <= zero_cnt;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= next_ptr(wr_ptr_r);
            end
            if (do_pop_s) begin
                rd_ptr_r <= next_ptr(rd_ptr_r);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + one_cnt;
                2'b01:   count_r <= count_r - one_cnt;
                default: count_r <= count_r;
            endcase
        end
    end

    // Flit storage; never cleared, a push during reset is discarded.
    always_ff @(posedge clk) begin
        if (do_push_s && !rst_n) begin
            mem_r[wr_ptr_r] <= data_in;
        end
    end

    // Fall-through read port and status flags.
    always_comb begin
        head_s = mem_r[rd_ptr_r];
        if (count_r == zero_cnt) begin
            data_out = {dw{1'b0}};
        end else begin
`ifdef LAG_ROUTE_EN
            data_out = route_flit(head_s);
`else
            data_out = head_s;
`endif
        end
        flags = {count_r == nfull_cnt, count_r == full_cnt,
                 count_r == one_cnt, count_r == zero_cnt};
    end

endmodule

// File: tb/tb_lag_fifo_v.sv
// Scoreboard bench for lag_fifo_v: a queue-based model predicts flags and data_out
// after every edge; a separate monitor compares them against the DUT.
module tb_lag_fifo_v;
    localparam int SIZE = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        push;
    logic        pop;
    logic [63:0] data_in;
    logic [63:0] data_out;
    logic [3:0]  flags;

    typedef struct packed {
        logic [3:0]  f;
        logic [63:0] d;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] model_q[$];
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    lag_fifo_v #(
        .size(SIZE), .dw(64), .head_bit(63), .router_radix(5),
        .x_addr_bits(2), .y_addr_bits(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .push(push), .pop(pop),
        .data_in(data_in), .data_out(data_out), .flags(flags)
    );

    // What the read side should show for a stored flit.
    function automatic logic [63:0] view(input logic [63:0] f);
`ifdef LAG_ROUTE_EN
        int x;
        int y;
        if (f[63]) begin
            x = $signed(f[7:5]);
            y = $signed(f[10:8]);
            if (x > 0)      f[4:0] = 5'b00010;
            else if (x < 0) f[4:0] = 5'b01000;
            else if (y > 0) f[4:0] = 5'b00001;
            else if (y < 0) f[4:0] = 5'b00100;
            else            f[4:0] = 5'b10000;
        end
`endif
        return f;
    endfunction

    function automatic exp_t expect_now();
        exp_t e;
        int n;
        n = model_q.size();
        e.f = {n == SIZE - 1, n == SIZE, n == 1, n == 0};
        e.d = (n > 0) ? view(model_q[0]) : 64'h0;
        return e;
    endfunction

    function automatic logic [63:0] mk(input bit h, input int x, input int y, input logic [4:0] lo);
        logic [63:0] f;
        f = {$urandom, $urandom};
        f[63] = h;
        f[7:5] = x[2:0];
        f[10:8] = y[2:0];
        f[4:0] = lo;
        return f;
    endfunction

    task automatic cycle(input bit r, input bit p, input bit o, input logic [63:0] d);
        int n;
        bit acc_pop;
        bit acc_push;
        @(negedge clk);
        rst_n = r; push = p; pop = o; data_in = d;
        n = model_q.size();
        acc_pop  = o && (n > 0);
        acc_push = p && ((n < SIZE) || acc_pop);
        if (r) begin
            model_q.delete();
        end else begin
            if (acc_pop) void'(model_q.pop_front());
            if (acc_push) model_q.push_back(d);
        end
        exp_q.push_back(expect_now());
    endtask

    // Monitor: compare DUT outputs after each edge against the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (flags !== e.f) begin
                    errors++;
                    $display("FAIL flags @%0t: got %b want %b", $time, flags, e.f);
                end
                checks++;
                if (data_out !== e.d) begin
                    errors++;
                    $display("FAIL data_out @%0t: got %h want %h", $time, data_out, e.d);
                end
            end
        end
    end

    initial begin
        int bias;
        rst_n = 1'b1; push = 1'b0; pop = 1'b0; data_in = 64'h0;
        cycle(1, 0, 0, 64'h0);
        cycle(0, 0, 0, 64'h0);
        cycle(0, 0, 0, 64'h0);
        cycle(0, 1, 0, 64'hA5);
        cycle(0, 0, 1, 64'h0);
        // fill, overflow, drain, underflow
        for (int i = 1; i <= 5; i++) cycle(0, 1, 0, 64'(i));
        for (int i = 0; i < 5; i++) cycle(0, 0, 1, 64'h0);
        // simultaneous push/pop when full and when empty
        for (int i = 1; i <= 4; i++) cycle(0, 1, 0, 64'(16 + i));
        cycle(0, 1, 1, 64'h77);
        for (int i = 0; i < 4; i++) cycle(0, 0, 1, 64'h0);
        cycle(0, 1, 1, 64'h88);
        cycle(0, 0, 1, 64'h0);
        // pointer wrap via alternating push/pop
        for (int i = 0; i < 10; i++) cycle(0, (i % 2) == 0, (i % 2) == 1, 64'(100 + i));
        // head and body flits carrying route fields
        cycle(0, 1, 0, mk(1, 1, 0, 5'b10101));
        cycle(0, 1, 0, mk(1, 0, -2, 5'b10101));
        cycle(0, 1, 0, mk(1, 0, 0, 5'b01010));
        cycle(0, 1, 0, mk(0, 1, 1, 5'b11011));
        for (int i = 0; i < 4; i++) cycle(0, 0, 1, 64'h0);
        cycle(0, 1, 0, mk(1, -1, 2, 5'b00000));
        cycle(0, 1, 0, mk(1, 0, 1, 5'b11111));
        cycle(0, 0, 1, 64'h0);
        cycle(0, 0, 1, 64'h0);
        // randomized traffic with phases biased toward full and toward empty
        for (int i = 0; i < 3000; i++) begin
            bias = ((i / 64) % 2 == 0) ? 3 : 1;
            cycle($urandom_range(0, 199) == 0, $urandom_range(0, 3) < bias,
                  $urandom_range(0, 3) >= bias, {$urandom, $urandom});
        end
        // reset while holding three flits and pushing
        cycle(1, 0, 0, 64'h0);
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 64'(200 + i));
        cycle(1, 1, 0, 64'h55);
        cycle(0, 0, 0, 64'h0);
        cycle(0, 0, 0, 64'h0);
        for (int i = 0; i < 8 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
